// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and the fetch-queue entry type for the
//                core front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int                      XLEN_DEFAULT     = 32;
   localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One buffered fetch: the instruction word and the address it came from.
   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] inst;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with occupancy output and a synchronous
//                flush. The head entry is read straight from storage and is
//                forced to zero while the FIFO is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic                   valid_o,
   output logic [WIDTH-1:0]       data_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int             PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             do_push;
   logic             do_pop;

   // Flush dominates: anything pushed or popped in a flush cycle is discarded.
   assign do_push = push_i & ~flush_i & (count_q != FULL);
   assign do_pop  = pop_i  & ~flush_i & (count_q != '0);

   // Pointer and occupancy next-state; flush returns to the empty state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care until counted as valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign valid_o = (count_q != '0);
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction-fetch front end. Issues sequential word-aligned
//                fetch requests, accepts in-order variable-latency responses,
//                buffers {pc, inst} pairs and flushes on redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_pc_plus_4
);

   localparam int             CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  rsp_pc_q,   rsp_pc_d;
   logic [CNT_W-1:0] outst_q,    outst_d;
   logic [CNT_W-1:0] drop_q,     drop_d;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   inflight;
   logic [XLEN-1:0]  redirect_base;
   logic             req_fire;
   logic             push;
   logic             pop;

   // Low two bits of the redirect target are simply cleared.
   assign redirect_base = redirect_pc & ~XLEN'(3);

   // Buffered plus in-flight entries never exceed DEPTH, so every response
   // that is kept always has a free FIFO slot waiting for it.
   assign inflight       = {1'b0, fifo_count} + {1'b0, outst_q};
   assign imem_req_valid = rst_n & ~redirect_valid & (inflight < DEPTH_W);
   assign imem_req_addr  = imem_req_valid ? fetch_pc_q : '0;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // Responses are kept only when nothing stale is still due and no redirect
   // is squashing the current cycle.
   assign push = imem_rsp_valid & ~redirect_valid & (drop_q == '0);
   assign pop  = inst_valid & inst_ready;

   // Fetch/response PC and in-flight bookkeeping.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
         fetch_pc_d = redirect_base;
         rsp_pc_d   = redirect_base;
         // drop_q is already a subset of outst_q, so after a redirect every
         // request still in flight is stale: drop exactly what remains
         // outstanding once this cycle's response (if any) is retired.
         drop_d     = outst_q - CNT_W'(imem_rsp_valid);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (imem_rsp_valid) begin
            if (drop_q != '0) drop_d   = drop_q - CNT_W'(1);
            else              rsp_pc_d = rsp_pc_q + XLEN'(4);
         end
      end
   end

   // Front-end state registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   sync_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect_valid),
      .push_i  (push),
      .data_i  ({rsp_pc_q, imem_rsp_data}),
      .pop_i   (pop),
      .valid_o (inst_valid),
      .data_o  ({inst_pc, inst_data}),
      .count_o (fifo_count)
   );

   assign inst_pc_plus_4 = inst_valid ? (inst_pc + XLEN'(4)) : '0;

   a_outst_bound: assert property (@(posedge clk) disable iff (!rst_n)
      outst_q <= CNT_W'(DEPTH));
   a_drop_le_outst: assert property (@(posedge clk) disable iff (!rst_n)
      drop_q <= outst_q);
   a_no_unrequested_rsp: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rsp_valid && (outst_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue with an
//                in-order fixed-latency instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
   import cpu_pkg::*;

   localparam logic [31:0] KEY = 32'h5EED_C0DE;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc_plus_4;

   always #5 clk = ~clk;

   fetch_queue #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_pc_plus_4 (inst_pc_plus_4)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   int           n_chk = 0;
   int           n_err = 0;
   int           cyc   = 0;
   int           lat   = 1;
   logic         rdy   = 1'b1;
   logic         rv;
   req_t         pend[$];
   fetch_entry_t pops[$];
   logic [31:0]  pops_pc4[$];
   logic [31:0]  issued[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pc_at(input int i);
      return (i < pops.size()) ? pops[i].pc : 32'hBAD0_BAD0;
   endfunction

   function automatic logic [31:0] pc4_at(input int i);
      return (i < pops_pc4.size()) ? pops_pc4[i] : 32'hBAD0_BAD0;
   endfunction

   function automatic logic [31:0] iss_at(input int i);
      return (i < issued.size()) ? issued[i] : 32'hBAD0_BAD0;
   endfunction

   // One clock cycle, entered and left 1ns after the rising edge.
   task automatic drive_cycle(input logic redir, input logic [31:0] rpc, output logic req_v);
      redirect_valid = redir;
      redirect_pc    = rpc;
      inst_ready     = rdy;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pend[0].addr ^ KEY;
         void'(pend.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      #1;
      req_v = imem_req_valid;
      if (imem_req_valid && imem_req_ready) begin
         pend.push_back('{imem_req_addr, cyc + lat});
         issued.push_back(imem_req_addr);
      end
      if (inst_valid && inst_ready && !redir) begin
         pops.push_back('{pc: inst_pc, inst: inst_data});
         pops_pc4.push_back(inst_pc_plus_4);
         check_eq("pop_data", inst_data, inst_pc ^ KEY);
         check_eq("pop_pc4", inst_pc_plus_4, inst_pc + 32'd4);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'h0, rv);
   endtask

   // Asserts reset mid-cycle, checks outputs before any clock edge, then
   // releases it 1ns after a rising edge so the next cycle starts cleanly.
   task automatic do_reset();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      rst_n          = 1'b0;
      #1;
      check_eq("rst_inst_valid", inst_valid, 32'd0);
      check_eq("rst_req_valid", imem_req_valid, 32'd0);
      check_eq("rst_req_addr", imem_req_addr, 32'd0);
      check_eq("rst_inst_pc", inst_pc, 32'd0);
      check_eq("rst_inst_data", inst_data, 32'd0);
      check_eq("rst_inst_pc4", inst_pc_plus_4, 32'd0);
      pend.delete();
      pops.delete();
      pops_pc4.delete();
      issued.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Streaming at latency 1: one instruction per cycle from PC 0.
      lat = 1; rdy = 1'b1;
      run(12);
      check_eq("seq_count", 32'(pops.size()), 32'd10);
      for (int i = 0; i < 10; i++) check_eq("seq_pc", pc_at(i), 32'(4 * i));

      // Consumer stalled: exactly DEPTH requests, then issue stops.
      do_reset();
      lat = 1; rdy = 1'b0;
      run(10);
      check_eq("full_issued", 32'(issued.size()), 32'd4);
      for (int i = 0; i < 4; i++) check_eq("full_addr", iss_at(i), 32'(4 * i));
      check_eq("full_req_valid", rv, 32'd0);
      check_eq("full_head_valid", inst_valid, 32'd1);
      check_eq("full_head_pc", inst_pc, 32'd0);
      rdy = 1'b1;
      run(10);
      for (int i = 0; i < 6; i++) check_eq("drain_pc", pc_at(i), 32'(4 * i));

      // Redirect to 0x103 with three requests in flight at latency 3.
      do_reset();
      lat = 3; rdy = 1'b1;
      run(3);
      drive_cycle(1'b1, 32'h0000_0103, rv);
      check_eq("redir_req_valid", rv, 32'd0);
      check_eq("redir_flush", inst_valid, 32'd0);
      check_eq("redir_no_pop", 32'(pops.size()), 32'd0);
      run(8);
      check_eq("redir_first_req", iss_at(3), 32'h0000_0100);
      check_eq("redir_pc0", pc_at(0), 32'h0000_0100);
      check_eq("redir_pc1", pc_at(1), 32'h0000_0104);
      check_eq("redir_pc2", pc_at(2), 32'h0000_0108);

      // Redirect coinciding with a response and a consumer pop.
      do_reset();
      lat = 1; rdy = 1'b1;
      run(3);
      drive_cycle(1'b1, 32'h0000_0200, rv);
      check_eq("same_flush", inst_valid, 32'd0);
      run(5);
      check_eq("same_count", 32'(pops.size()), 32'd4);
      check_eq("same_pc0", pc_at(0), 32'h0000_0000);
      check_eq("same_pc1", pc_at(1), 32'h0000_0200);
      check_eq("same_pc2", pc_at(2), 32'h0000_0204);

      // Back-to-back redirects: all older in-flight responses are dropped.
      do_reset();
      lat = 3; rdy = 1'b1;
      run(2);
      drive_cycle(1'b1, 32'h0000_0300, rv);
      drive_cycle(1'b1, 32'h0000_0400, rv);
      run(7);
      check_eq("b2b_pc0", pc_at(0), 32'h0000_0400);
      check_eq("b2b_pc1", pc_at(1), 32'h0000_0404);

      // Address wrap at the top of the address space.
      do_reset();
      lat = 1; rdy = 1'b1;
      drive_cycle(1'b1, 32'hFFFF_FFF8, rv);
      run(6);
      check_eq("wrap_req0", iss_at(0), 32'hFFFF_FFF8);
      check_eq("wrap_req1", iss_at(1), 32'hFFFF_FFFC);
      check_eq("wrap_req2", iss_at(2), 32'h0000_0000);
      check_eq("wrap_pc1", pc_at(1), 32'hFFFF_FFFC);
      check_eq("wrap_pc4", pc4_at(1), 32'h0000_0000);
      check_eq("wrap_pc2", pc_at(2), 32'h0000_0000);

      // Reset mid-stream with a request outstanding.
      do_reset();
      lat = 1; rdy = 1'b1;
      run(4);
      check_eq("pre_rst_valid", inst_valid, 32'd1);
      do_reset();
      run(4);
      check_eq("post_rst_req", iss_at(0), 32'h0000_0000);
      check_eq("post_rst_pc0", pc_at(0), 32'h0000_0000);
      check_eq("post_rst_pc1", pc_at(1), 32'h0000_0004);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
